pipeline_hazard_ctrl: RTL and testbench

// Hazard and forwarding controller for the five-stage IF/ID/EX/MEM/WB pipeline.
// - Keeps its own shadow pipeline of destination register, RF write-enable and load flag for EX, MEM and WB.
// - Drives the ID forwarding-mux selects A_S/B_S and the load-use stall (PC/IF-ID LE, CU NOP select).
// - Squashes the fetched instruction after a taken branch/jump resolved in EX; the delay slot in ID still executes.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 34 +++
 rtl/pipeline_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared constants and types for the pipeline hazard/forwarding
//               controller (forward-select encodings, shadow-pipe entry).
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // Register-address width; GR0 is hard-wired zero and never forwarded
    localparam int RW        = 5;
    // Default width of the saturating performance counters
    localparam int CNT_W_DEF = 16;

    // Forwarding-mux select encodings (FPA/FPB)
    localparam logic [1:0] FW_RF  = 2'b00;
    localparam logic [1:0] FW_EX  = 2'b01;
    localparam logic [1:0] FW_MEM = 2'b10;
    localparam logic [1:0] FW_WB  = 2'b11;

    // One shadow-pipe entry: destination register, RF write enable, load flag
    typedef struct packed {
        logic [RW-1:0] rd;
        logic          le;
        logic          l;
    } shadow_t;

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : ID-stage operand info, branch resolve and hazard-control
//               outputs exchanged between the datapath and the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic [RW-1:0]    id_ra;
    logic [RW-1:0]    id_rb;
    logic             id_use_a;
    logic             id_use_b;
    logic [RW-1:0]    id_rd;
    logic             id_rf_le;
    logic             id_l;
    logic             ex_j;
    logic [1:0]       a_s;
    logic [1:0]       b_s;
    logic             le;
    logic             nop_s;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] sqsh_cnt;

    // Datapath side: supplies ID/EX information, consumes control
    modport master (
        output id_ra, id_rb, id_use_a, id_use_b, id_rd, id_rf_le, id_l, ex_j,
        input  a_s, b_s, le, nop_s, flush, stall_cnt, sqsh_cnt
    );

    // Controller side
    modport slave (
        input  id_ra, id_rb, id_use_a, id_use_b, id_rd, id_rf_le, id_l, ex_j,
        output a_s, b_s, le, nop_s, flush, stall_cnt, sqsh_cnt
    );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_fwd_select
// Description : Priority comparator choosing the forwarding source for one
//               ID operand from the EX/MEM/WB shadow entries.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl_fwd_select
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic          i_use,
    input  logic [RW-1:0] i_src,
    input  shadow_t       i_ex,
    input  shadow_t       i_mem,
    input  shadow_t       i_wb,
    output logic [1:0]    o_sel
);

    // Youngest matching writer wins; GR0 reads always come from the RF
    always_comb begin
        o_sel = FW_RF;
        if (i_use && (i_src != '0)) begin
            if (i_ex.le && (i_ex.rd == i_src)) begin
                o_sel = FW_EX;
            end else if (i_mem.le && (i_mem.rd == i_src)) begin
                o_sel = FW_MEM;
            end else if (i_wb.le && (i_wb.rd == i_src)) begin
                o_sel = FW_WB;
            end
        end
    end

endmodule : pipeline_hazard_ctrl_fwd_select
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard and forwarding controller for the five-stage pipeline:
//               shadow EX/MEM/WB pipe, operand forwarding selects, load-use
//               stall, post-branch fetch squash and saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    shadow_t          r_ex;
    shadow_t          r_mem;
    shadow_t          r_wb;
    logic             r_sqsh;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_sqsh_cnt;

    logic             w_id_valid;
    logic             w_use_a;
    logic             w_use_b;
    logic             w_ld_hit;
    logic             w_stall;
    shadow_t          w_id_entry;

    // A squashed fetch in ID is invisible: it reads nothing and writes nothing
    assign w_id_valid = ~r_sqsh;
    assign w_use_a    = w_id_valid & bus.id_use_a;
    assign w_use_b    = w_id_valid & bus.id_use_b;
    assign w_id_entry = '{rd: bus.id_rd, le: bus.id_rf_le, l: bus.id_l};

    // Load in EX whose result an ID source needs cannot be forwarded yet
    assign w_ld_hit = r_ex.l && r_ex.le && (r_ex.rd != '0) &&
                      ((w_use_a && (bus.id_ra == r_ex.rd)) ||
                       (w_use_b && (bus.id_rb == r_ex.rd)));
    // A taken branch overrides the stall (defensive; cannot coexist with a load)
    assign w_stall  = w_ld_hit && !bus.ex_j;

    assign bus.le        = ~w_stall;
    assign bus.nop_s     = w_stall;
    assign bus.flush     = bus.ex_j & i_rst_n;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.sqsh_cnt  = r_sqsh_cnt;

    pipeline_hazard_ctrl_fwd_select u_fwd_a (
        .i_use (w_use_a),
        .i_src (bus.id_ra),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (bus.a_s)
    );

    pipeline_hazard_ctrl_fwd_select u_fwd_b (
        .i_use (w_use_b),
        .i_src (bus.id_rb),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .i_wb  (r_wb),
        .o_sel (bus.b_s)
    );

    // Shadow pipe advances every edge; EX takes a bubble on stall or squash
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex   <= '0;
            r_mem  <= '0;
            r_wb   <= '0;
            r_sqsh <= 1'b0;
        end else begin
            r_wb   <= r_mem;
            r_mem  <= r_ex;
            r_ex   <= (w_stall || r_sqsh) ? shadow_t'('0) : w_id_entry;
            r_sqsh <= bus.ex_j;
        end
    end

    // Saturating stall / squash performance counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_sqsh_cnt  <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (bus.ex_j && (r_sqsh_cnt != c_cnt_max)) begin
                r_sqsh_cnt <= r_sqsh_cnt + c_cnt_one;
            end
        end
    end

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed-vector scoreboard bench for pipeline_hazard_ctrl.
//               Counters are built 4 bits wide so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int TB_CNT_W = 4;

    typedef struct {
        string                name;
        logic [1:0]           a_s;
        logic [1:0]           b_s;
        logic                 le;
        logic                 nop_s;
        logic                 flush;
        logic [TB_CNT_W-1:0]  sc;
        logic [TB_CNT_W-1:0]  qc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    pipeline_hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle of ID/EX inputs and queue the expected control outputs
    task automatic step(input string nm, input logic rv,
                        input logic [4:0] ra, input logic ua,
                        input logic [4:0] rb, input logic ub,
                        input logic [4:0] rd, input logic rfle, input logic ld,
                        input logic j,
                        input logic [1:0] ea, input logic [1:0] eb,
                        input logic ele, input logic enop, input logic efl,
                        input int esc, input int eqc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rv;
        bus.id_ra    = ra;
        bus.id_use_a = ua;
        bus.id_rb    = rb;
        bus.id_use_b = ub;
        bus.id_rd    = rd;
        bus.id_rf_le = rfle;
        bus.id_l     = ld;
        bus.ex_j     = j;
        e.name  = nm;
        e.a_s   = ea;
        e.b_s   = eb;
        e.le    = ele;
        e.nop_s = enop;
        e.flush = efl;
        e.sc    = TB_CNT_W'(esc);
        e.qc    = TB_CNT_W'(eqc);
        sb_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest queued entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (bus.a_s !== e.a_s || bus.b_s !== e.b_s || bus.le !== e.le ||
                    bus.nop_s !== e.nop_s || bus.flush !== e.flush ||
                    bus.stall_cnt !== e.sc || bus.sqsh_cnt !== e.qc) begin
                    n_err++;
                    $display("FAIL %s: got a_s=%b b_s=%b le=%b nop_s=%b flush=%b stall_cnt=%0d sqsh_cnt=%0d, want a_s=%b b_s=%b le=%b nop_s=%b flush=%b stall_cnt=%0d sqsh_cnt=%0d",
                             e.name, bus.a_s, bus.b_s, bus.le, bus.nop_s, bus.flush,
                             bus.stall_cnt, bus.sqsh_cnt, e.a_s, e.b_s, e.le,
                             e.nop_s, e.flush, e.sc, e.qc);
                end
            end
        end
    end

    // Directed stimulus; each row: ra,ua, rb,ub, rd,rf_le,l, ex_j -> expectations
    initial begin
        int s;
        bus.id_ra = '0; bus.id_use_a = 1'b0; bus.id_rb = '0; bus.id_use_b = 1'b0;
        bus.id_rd = '0; bus.id_rf_le = 1'b0; bus.id_l = 1'b0; bus.ex_j = 1'b0;

        // Reset state with busy inputs: flush suppressed, everything idle
        step("rst_state", 0, 1,1, 1,1, 1,1,1, 1, 2'b00,2'b00,1,0,0, 0,0);

        // ADD r3<-r1,r2 ; SUB r4<-r3,r5 ; then r3 read from MEM, then WB
        step("add_r3",    1, 1,1, 2,1, 3,1,0, 0, 2'b00,2'b00,1,0,0, 0,0);
        step("fwd_ex",    1, 3,1, 5,1, 4,1,0, 0, 2'b01,2'b00,1,0,0, 0,0);
        step("fwd_mem",   1, 3,1, 0,0, 0,0,0, 0, 2'b10,2'b00,1,0,0, 0,0);
        step("fwd_wb",    1, 3,1, 0,0, 0,0,0, 0, 2'b11,2'b00,1,0,0, 0,0);

        // LDW r7 ; ADD r8<-r7,r7 : one stall cycle then MEM forwarding
        step("ldw_r7",    1, 0,0, 0,0, 7,1,1, 0, 2'b00,2'b00,1,0,0, 0,0);
        step("ld_stall",  1, 7,1, 7,1, 8,1,0, 0, 2'b01,2'b01,0,1,0, 0,0);
        step("ld_fwd",    1, 7,1, 7,1, 8,1,0, 0, 2'b10,2'b10,1,0,0, 1,0);
        step("idle1",     1, 0,0, 0,0, 0,0,0, 0, 2'b00,2'b00,1,0,0, 1,0);

        // Load to r0 followed by r0 reads: no forwarding, no stall
        step("ldw_r0",    1, 0,0, 0,0, 0,1,1, 0, 2'b00,2'b00,1,0,0, 1,0);
        step("read_r0",   1, 0,1, 0,1, 0,0,0, 0, 2'b00,2'b00,1,0,0, 1,0);

        // Branch in EX with delay slot in ID; next fetch squashed
        step("wr_r11",    1, 0,0, 0,0, 11,1,0, 0, 2'b00,2'b00,1,0,0, 1,0);
        step("br_slot",   1, 11,1, 0,0, 10,1,0, 1, 2'b01,2'b00,1,0,1, 1,0);
        step("squashed",  1, 10,1, 0,0, 12,1,1, 0, 2'b00,2'b00,1,0,0, 1,1);
        step("post_sqsh", 1, 12,1, 10,1, 0,0,0, 0, 2'b00,2'b10,1,0,0, 1,1);

        // Three writers of r9, then readers: EX wins, unused source ignored
        step("wr_r9_a",   1, 0,0, 0,0, 9,1,0, 0, 2'b00,2'b00,1,0,0, 1,1);
        step("wr_r9_b",   1, 0,0, 0,0, 9,1,0, 0, 2'b00,2'b00,1,0,0, 1,1);
        step("wr_r9_c",   1, 0,0, 0,0, 9,1,0, 0, 2'b00,2'b00,1,0,0, 1,1);
        step("r9_ex_win", 1, 9,1, 9,0, 0,0,0, 0, 2'b01,2'b00,1,0,0, 1,1);
        step("r9_usea0",  1, 9,0, 9,1, 0,0,0, 0, 2'b00,2'b10,1,0,0, 1,1);

        // Reset asserted right after a stall cycle: all state cleared at once
        step("ldw_r5",    1, 0,0, 0,0, 5,1,1, 0, 2'b00,2'b00,1,0,0, 1,1);
        step("r5_stall",  1, 5,1, 0,0, 0,0,0, 0, 2'b01,2'b00,0,1,0, 1,1);
        step("rst_mid",   0, 5,1, 0,0, 0,0,0, 1, 2'b00,2'b00,1,0,0, 0,0);
        step("rst_rel",   1, 5,1, 0,0, 0,0,0, 0, 2'b00,2'b00,1,0,0, 0,0);

        // 17 load-use stalls against a 4-bit counter: saturates at 15
        for (int k = 0; k < 17; k++) begin
            s = (k > 15) ? 15 : k;
            step("sat_ld",    1, 0,0, 0,0, 6,1,1, 0, 2'b00,2'b00,1,0,0, s,0);
            step("sat_stall", 1, 6,1, 0,0, 0,0,0, 0, 2'b01,2'b00,0,1,0, s,0);
        end

        // Branch coinciding with a load-use hit: branch wins, no stall
        step("prio_ld",   1, 0,0, 0,0, 6,1,1, 0, 2'b00,2'b00,1,0,0, 15,0);
        step("prio_j",    1, 6,1, 0,0, 0,0,0, 1, 2'b01,2'b00,1,0,1, 15,0);
        step("post_j",    1, 0,0, 0,0, 0,0,0, 0, 2'b00,2'b00,1,0,0, 15,1);

        // Let the monitor drain the scoreboard, bounded
        for (int w = 0; w < 5 && sb_q.size() > 0; w++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: entries left=%0d, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
